mc_controller: RTL and testbench

Multicycle control unit for the ARM-subset processor. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback, one state per clock. It holds the NZCV flags and evaluates condition codes. The core top instantiates it beside the multicycle datapath, in place of the single-cycle decoder.

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/mc_if.sv | 28 ++
 rtl/mc_cond_unit.sv | 61 ++++++
 rtl/mc_controller.sv | 160 ++++++++++++++++
 tb/tb_mc_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecR,
        StExecI,
        StAluWb,
        StBranch
    } state_e;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] OpDp     = 2'b00;
    localparam logic [1:0] OpMem    = 2'b01;
    localparam logic [1:0] OpBranch = 2'b10;
    localparam logic [1:0] OpNop    = 2'b11;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;
    localparam logic [3:0] CondNv = 4'b1111;

endpackage

// File: rtl/mc_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mc_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite;
    logic         AdrSrc;
    logic         MemWrite;
    logic         IRWrite;
    logic [1:0]   ResultSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ALUControl;
    logic [1:0]   ImmSrc;
    logic [1:0]   RegSrc;
    logic         RegWrite;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite
    );
endinterface

// File: rtl/mc_cond_unit.sv
// NZCV flag register and condition evaluation; condex_q is latched once per
// instruction and gates every conditional write that follows.
module mc_cond_unit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_latch,
    output logic       condex_q
);

    logic [3:0] flags_q;
    logic       n, z, c, v;
    logic       condex;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        condex = 1'b0;
        unique case (cond)
            CondEq:  condex = z;
            CondNe:  condex = !z;
            CondCs:  condex = c;
            CondCc:  condex = !c;
            CondMi:  condex = n;
            CondPl:  condex = !n;
            CondVs:  condex = v;
            CondVc:  condex = !v;
            CondHi:  condex = c && !z;
            CondLs:  condex = !c || z;
            CondGe:  condex = (n == v);
            CondLt:  condex = (n != v);
            CondGt:  condex = !z && (n == v);
            CondLe:  condex = z || (n != v);
            CondAl:  condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // flag_w is only non-zero in the execute states, so it doubles as the update enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            if (cond_latch) begin
                condex_q <= condex;
            end
            if (condex_q && flag_w[1]) begin
                flags_q[3:2] <= alu_flags[3:2];
            end
            if (condex_q && flag_w[0]) begin
                flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and
// decodes ALU and datapath mux controls from the latched instruction.
module mc_controller
    import mc_pkg::*;
(
    input logic  clk,
    input logic  reset,
    mc_if.master bus
);

    state_e     state_q, state_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    logic       regw, memw, nextpc, branch, aluop;
    logic       pcs, condex_q;
    logic [1:0] flag_w;
    logic [1:0] alu_control;
    logic       adr_src, ir_write, alu_src_a;
    logic [1:0] result_src, alu_src_b;

    assign op        = bus.Instr[27:26];
    assign funct     = bus.Instr[25:20];
    assign rd        = bus.Instr[15:12];
    assign unused_rn = ^bus.Instr[19:16];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (op)
                    OpMem:    state_d = StMemAdr;
                    OpDp:     state_d = funct[5] ? StExecI : StExecR;
                    OpBranch: state_d = StBranch;
                    default:  state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        regw       = 1'b0;
        memw       = 1'b0;
        nextpc     = 1'b0;
        branch     = 1'b0;
        aluop      = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = 1'b0;
        result_src = ResAluOut;
        alu_src_b  = SrcBRd2;
        unique case (state_q)
            StFetch: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                nextpc     = 1'b1;
            end
            StDecode: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
            end
            StMemAdr: alu_src_b = SrcBImm;
            StMemRd:  adr_src = 1'b1;
            StMemWb: begin
                result_src = ResData;
                regw       = 1'b1;
            end
            StMemWr: begin
                adr_src = 1'b1;
                memw    = 1'b1;
            end
            StExecR:  aluop = 1'b1;
            StExecI: begin
                alu_src_b = SrcBImm;
                aluop     = 1'b1;
            end
            StAluWb:  regw = 1'b1;
            StBranch: begin
                alu_src_b  = SrcBImm;
                result_src = ResAluResult;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    // Unrecognised ALU functions fall back to ADD and never touch the flags.
    always_comb begin
        alu_control = AluAdd;
        flag_w      = 2'b00;
        if (aluop) begin
            case (funct[4:1])
                4'b0100: begin
                    alu_control = AluAdd;
                    flag_w      = {funct[0], funct[0]};
                end
                4'b0010: begin
                    alu_control = AluSub;
                    flag_w      = {funct[0], funct[0]};
                end
                4'b0000: begin
                    alu_control = AluAnd;
                    flag_w      = {funct[0], 1'b0};
                end
                4'b1100: begin
                    alu_control = AluOrr;
                    flag_w      = {funct[0], 1'b0};
                end
                default: begin
                    alu_control = AluAdd;
                    flag_w      = 2'b00;
                end
            endcase
        end
    end

    mc_cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (bus.Instr[31:28]),
        .alu_flags  (bus.ALUFlags),
        .flag_w     (flag_w),
        .cond_latch (state_q == StDecode),
        .condex_q   (condex_q)
    );

    assign pcs = (regw && (rd == 4'd15)) || branch;

    assign bus.PCWrite    = nextpc || (pcs && condex_q);
    assign bus.RegWrite   = regw && condex_q;
    assign bus.MemWrite   = memw && condex_q;
    assign bus.AdrSrc     = adr_src;
    assign bus.IRWrite    = ir_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == OpMem, op == OpBranch};

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction expected control words
// from an instruction-level model with NZCV flags, random and directed programs.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] mflags;

    mc_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc,
                bus.RegWrite};
    endfunction

    function automatic logic [15:0] word(input logic pcw, input logic adr, input logic memw,
                                         input logic irw, input logic [1:0] res,
                                         input logic srca, input logic [1:0] srcb,
                                         input logic [1:0] alu, input logic [1:0] op,
                                         input logic regw);
        logic [1:0] regsrc;
        regsrc = {op == 2'b01, op == 2'b10};
        return {pcw, adr, memw, irw, res, srca, srcb, alu, op, regsrc, regw};
    endfunction

    // ARM-style: pairs of conditions share a base test, odd codes invert it.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        return cond[0] ? ~base : base;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] f);
        case (f)
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int ncycles(input logic [19:0] ins);
        case (ins[15:14])
            2'b11:   return 2;
            2'b10:   return 3;
            2'b00:   return 4;
            default: return ins[8] ? 5 : 4;
        endcase
    endfunction

    // Expected control word at cycle k of an instruction (k=0 is the fetch cycle).
    function automatic logic [15:0] exp_word(input logic [19:0] ins, input logic cx, input int k);
        logic [1:0] op;
        logic [5:0] funct;
        logic       pc_dest;
        op      = ins[15:14];
        funct   = ins[13:8];
        pc_dest = cx && (ins[3:0] == 4'd15);
        if (k == 0) return word(1, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, op, 0);
        if (k == 1) return word(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, op, 0);
        case (op)
            2'b00: begin
                if (k == 2)
                    return word(0, 0, 0, 0, 2'b00, 0, funct[5] ? 2'b01 : 2'b00,
                                alu_of(funct[4:1]), op, 0);
                return word(pc_dest, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, op, cx);
            end
            2'b01: begin
                if (k == 2) return word(0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, op, 0);
                if (!funct[0]) return word(0, 1, cx, 0, 2'b00, 0, 2'b00, 2'b00, op, 0);
                if (k == 3) return word(0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, op, 0);
                return word(pc_dest, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, op, cx);
            end
            default: return word(cx, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, op, 0);
        endcase
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        logic [3:0] rn;
        rn = 4'($urandom);
        return {cond, op, funct, rn, rd};
    endfunction

    // Called just after an edge that leaves the DUT in the fetch state.
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input int abort_at);
        int         n;
        logic       cx;
        logic [5:0] funct;
        logic [3:0] op4;
        n     = ncycles(ins);
        funct = ins[13:8];
        cx    = cond_ok(ins[19:16], mflags);
        bus.Instr    = ins;
        bus.ALUFlags = af;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_eq($sformatf("ctl_op%0d_k%0d", ins[15:14], k), 32'(obs()),
                     32'(exp_word(ins, cx, k)));
            if (k == 2 && ins[15:14] == 2'b00 && cx && funct[0]) begin
                op4 = funct[4:1];
                if (op4 == 4'b0100 || op4 == 4'b0010 || op4 == 4'b0000 || op4 == 4'b1100)
                    mflags[3:2] = af[3:2];
                if (op4 == 4'b0100 || op4 == 4'b0010)
                    mflags[1:0] = af[1:0];
            end
            if (k == abort_at) begin
                #1;
                reset     = 1'b0;
                bus.Instr = '0;
                mflags    = 4'b0000;
                #1;
                check_eq("rst_async", 32'(obs()), 32'(exp_word(20'h0, 1'b0, 0)));
                @(posedge clk);
                #1;
                check_eq("rst_hold", 32'(obs()), 32'(exp_word(20'h0, 1'b0, 0)));
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.Instr    = '0;
        bus.ALUFlags = '0;
        mflags       = 4'b0000;
        #1;
        check_eq("rst_init", 32'(obs()), 32'(exp_word(20'h0, 1'b0, 0)));
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_init_hold", 32'(obs()), 32'(exp_word(20'h0, 1'b0, 0)));
        reset = 1'b1;

        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'd1), 4'($urandom), -1);  // ADD
        run_instr(mk(4'hE, 2'b00, 6'b000101, 4'd2), 4'b0100, -1);       // SUBS -> Z
        run_instr(mk(4'h0, 2'b00, 6'b001000, 4'd3), 4'b0000, -1);       // ADDEQ
        run_instr(mk(4'h1, 2'b00, 6'b001000, 4'd3), 4'b0000, -1);       // ADDNE
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'd4), 4'b0000, -1);       // LDR
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'd4), 4'b0000, -1);       // STR
        run_instr(mk(4'hE, 2'b10, 6'b101010, 4'd0), 4'b0000, -1);       // B
        run_instr(mk(4'h1, 2'b10, 6'b101010, 4'd0), 4'b0000, -1);       // BNE, Z=1
        run_instr(mk(4'hE, 2'b00, 6'b001001, 4'd5), 4'b1111, -1);       // ADDS -> 1111
        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'd1), 4'b0000, 2);        // reset in EXECR
        run_instr(mk(4'h4, 2'b00, 6'b001000, 4'd1), 4'b0000, -1);       // ADDMI after reset
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'd0), 4'b0000, -1);       // op=11
        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'd15), 4'b0000, -1);      // ADD to PC
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'd15), 4'b0000, -1);      // LDR to PC

        for (int i = 0; i < 400; i++) begin
            logic [5:0]  funct;
            logic [19:0] ins;
            int          abort_at;
            funct = 6'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 3))
                    0: funct[4:1] = 4'b0100;
                    1: funct[4:1] = 4'b0010;
                    2: funct[4:1] = 4'b0000;
                    default: funct[4:1] = 4'b1100;
                endcase
            end
            ins      = mk(4'($urandom), 2'($urandom), funct, 4'($urandom));
            abort_at = ($urandom_range(0, 24) == 0) ? $urandom_range(0, ncycles(ins) - 1) : -1;
            run_instr(ins, 4'($urandom), abort_at);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
